// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the SRAM AXI slaves.
package sram_axi_pkg;

  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;
  localparam int unsigned AXI_DATA_BITS = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DATA  = 2'd3
  } rd_state_e;

  // Burst attributes held constant for the life of a burst.
  typedef struct packed {
    logic [AXI_IDS_BITS-1:0]  id;
    logic [AXI_SIZE_BITS-1:0] size;
    logic [1:0]               burst;
  } ar_ctrl_t;

endpackage

// File: rtl/sram_slave_read_addr_gen.sv
// Next beat address for an AXI burst; FIXED holds, everything else increments.
module axi_burst_addr_gen
  import sram_axi_pkg::*;
(
  input  logic [AXI_ADDR_BITS-1:0] addr,
  input  logic [AXI_SIZE_BITS-1:0] size,
  input  logic [1:0]               burst,
  output logic [AXI_ADDR_BITS-1:0] next_addr_c
);

  // WRAP and reserved types fall back to plain increment, 32-bit modulo.
  always_comb begin
    next_addr_c = addr + (AXI_ADDR_BITS'(1) << size);
    if (burst == BURST_FIXED) begin
      next_addr_c = addr;
    end
  end

endmodule

// File: rtl/sram_slave_read.sv
// AXI4 read slave for the on-chip SRAM: one burst at a time, one SRAM access per beat.
module sram_slave_read
  import sram_axi_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_IDS_BITS-1:0]  ARID,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     isnot_writing,
  output logic                     isnot_reading,
  output logic [AXI_ADDR_BITS-1:0] A,
  output logic                     CEB,
  input  logic [AXI_DATA_BITS-1:0] DO
);

  localparam int unsigned      LAT_W    = 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  rd_state_e                state;
  rd_state_e                state_nxt;
  ar_ctrl_t                 ctrl_q;
  logic [AXI_ADDR_BITS-1:0] cur_addr;
  logic [AXI_ADDR_BITS-1:0] next_addr_c;
  logic [AXI_LEN_BITS-1:0]  beats_left;
  logic [LAT_W-1:0]         lat_cnt;
  logic [AXI_DATA_BITS-1:0] rdata_reg;
  logic                     ar_hs_c;
  logic                     beat_hs_c;
  logic                     last_c;

  assign last_c = (beats_left == '0);

  axi_burst_addr_gen u_addr_gen (
    .addr        (cur_addr),
    .size        (ctrl_q.size),
    .burst       (ctrl_q.burst),
    .next_addr_c (next_addr_c)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded bus/SRAM outputs.
  always_comb begin
    state_nxt     = state;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    RLAST         = 1'b0;
    RDATA         = '0;
    RID           = '0;
    RRESP         = RESP_OKAY;
    A             = '0;
    CEB           = 1'b1;
    isnot_reading = 1'b1;
    ar_hs_c       = 1'b0;
    beat_hs_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        // ARREADY tracks the write slave combinationally so contention blocks the handshake.
        ARREADY = isnot_writing & ARESETn;
        ar_hs_c = ARVALID & isnot_writing & ARESETn;
        if (ar_hs_c) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        CEB           = 1'b0;
        A             = cur_addr;
        isnot_reading = 1'b0;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        isnot_reading = 1'b0;
        if (lat_cnt == '0) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        RVALID        = 1'b1;
        RDATA         = rdata_reg;
        RID           = ctrl_q.id;
        RLAST         = last_c;
        isnot_reading = 1'b0;
        if (RREADY) begin
          beat_hs_c = 1'b1;
          state_nxt = last_c ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping, latency counter and read-data capture.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ctrl_q     <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      lat_cnt    <= '0;
      rdata_reg  <= '0;
    end else begin
      if (ar_hs_c) begin
        ctrl_q.id    <= ARID;
        ctrl_q.size  <= ARSIZE;
        ctrl_q.burst <= ARBURST;
        cur_addr     <= ARADDR;
        beats_left   <= ARLEN;
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= LAT_INIT;
      end
      if (state == ST_WAIT) begin
        if (lat_cnt == '0) begin
          rdata_reg <= DO;
        end else begin
          lat_cnt <= lat_cnt - LAT_W'(1);
        end
      end
      if (beat_hs_c && !last_c) begin
        beats_left <= beats_left - AXI_LEN_BITS'(1);
        cur_addr   <= next_addr_c;
      end
    end
  end

endmodule

// File: tb/tb_sram_slave_read.sv
// Bench for sram_slave_read: two instances (MEM_LAT 1 and 2) against a burst-level model.
module tb_sram_slave_read;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isnot_writing;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arvalid;
  logic        rready;

  logic [1:0]  arready, rvalid, rlast, ceb, isnot_reading;
  logic [7:0]  rid    [2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic [31:0] a_out  [2];
  logic [31:0] do_in  [2];
  logic [31:0] pipe1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] a_log [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  logic [7:0]  got_id [$];
  logic [1:0]  got_resp [$];
  int          got_first [$];
  logic [31:0] st_data [$];
  logic        st_last [$];
  int          st_alog [$];
  logic        st_ceb [$];

  always #5 clk = ~clk;

  sram_slave_read #(.MEM_LAT(1)) u_dut0 (
    .ACLK(clk), .ARESETn(rst_n), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen),
    .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
    .RID(rid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RLAST(rlast[0]), .RVALID(rvalid[0]),
    .RREADY(rready), .isnot_writing(isnot_writing), .isnot_reading(isnot_reading[0]),
    .A(a_out[0]), .CEB(ceb[0]), .DO(do_in[0])
  );

  sram_slave_read #(.MEM_LAT(2)) u_dut1 (
    .ACLK(clk), .ARESETn(rst_n), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen),
    .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
    .RID(rid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RLAST(rlast[1]), .RVALID(rvalid[1]),
    .RREADY(rready), .isnot_writing(isnot_writing), .isnot_reading(isnot_reading[1]),
    .A(a_out[1]), .CEB(ceb[1]), .DO(do_in[1])
  );

  // SRAM contents: explicit entries, otherwise a fixed hash of the byte address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'hA5A5_0F0F) * 32'h9E37_79B1;
  endfunction

  // Expected address of beat i of a burst.
  function automatic logic [31:0] exp_addr(input logic [31:0] start, input int i,
                                           input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return start;
    return start + 32'(i) * (32'd1 << size);
  endfunction

  // SRAM models (latency 1 and 2) plus a log of every CEB-low access.
  always @(posedge clk) begin
    if (!ceb[0]) do_in[0] <= mem_rd(a_out[0]);
    if (!ceb[1]) pipe1 <= mem_rd(a_out[1]);
    do_in[1] <= pipe1;
    if (!ceb[0]) a_log.push_back(a_out[0]);
    if (!ceb[1]) a_log.push_back(a_out[1]);
  end

  task automatic do_ar(input int sel, input logic [7:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid[sel] = 1'b1;
    a_log.delete();
    while (!arready[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL ar_handshake_timeout dut%0d waited %0d cycles", sel, n);
    end
    @(posedge clk);
    #1 arvalid[sel] = 1'b0;
  endtask

  task automatic collect(input int sel, input int nbeats, input int stall_beat, input int stall_cyc);
    int cyc = 0;
    int beat = 0;
    int stall_left = stall_cyc;
    bit seen = 1'b0;
    got_data.delete(); got_last.delete(); got_id.delete(); got_resp.delete(); got_first.delete();
    st_data.delete(); st_last.delete(); st_alog.delete(); st_ceb.delete();
    rready = 1'b1;
    while (beat < nbeats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rvalid[sel]) begin
        if (!seen) begin
          got_first.push_back(cyc);
          seen = 1'b1;
        end
        if (beat == stall_beat && stall_left > 0) begin
          rready = 1'b0;
          stall_left--;
          st_data.push_back(rdata[sel]); st_last.push_back(rlast[sel]);
          st_alog.push_back(a_log.size()); st_ceb.push_back(ceb[sel]);
        end else begin
          rready = 1'b1;
          got_data.push_back(rdata[sel]); got_last.push_back(rlast[sel]);
          got_id.push_back(rid[sel]); got_resp.push_back(rresp[sel]);
          beat++;
          seen = 1'b0;
        end
      end
    end
    checks++;
    if (beat < nbeats) begin
      errors++;
      $display("FAIL r_beat_timeout dut%0d got %0d beats exp %0d", sel, beat, nbeats);
    end
    @(posedge clk);
    #1 rready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; isnot_writing = 1'b1; arvalid = 2'b00; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({arready[s], rvalid[s], rlast[s], ceb[s], isnot_reading[s]} !== 5'b00011) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got %b exp 00011", s,
                 {arready[s], rvalid[s], rlast[s], ceb[s], isnot_reading[s]});
      end
      checks++;
      if ({a_out[s], rdata[s], rid[s], rresp[s]} !== 74'd0) begin
        errors++;
        $display("FAIL reset_data dut%0d A %h RDATA %h RID %h RRESP %h exp 0", s,
                 a_out[s], rdata[s], rid[s], rresp[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (arready !== 2'b11) begin
      errors++;
      $display("FAIL arready_after_reset got %b exp 11", arready);
    end
    isnot_writing = 1'b0;
    #1;
    checks++;
    if (arready !== 2'b00) begin
      errors++;
      $display("FAIL arready_follows_writing got %b exp 00", arready);
    end
    isnot_writing = 1'b1;
    rready = 1'b1;
  endtask

  task automatic test_single;
    mem[32'h100] = 32'hDEAD_BEEF;
    do_ar(0, 8'h05, 32'h100, 4'd0, 3'd2, 2'b01);
    collect(0, 1, -1, 0);
    checks++;
    if (got_first[0] !== 3) begin
      errors++; $display("FAIL single_latency got %0d exp 3", got_first[0]);
    end
    checks++;
    if ({got_data[0], got_id[0], got_last[0], got_resp[0]} !== {32'hDEAD_BEEF, 8'h05, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL single_beat RDATA %h RID %h RLAST %b RRESP %b exp DEADBEEF 05 1 00",
               got_data[0], got_id[0], got_last[0], got_resp[0]);
    end
    checks++;
    if (a_log.size() != 1 || a_log[0] !== 32'h100) begin
      errors++; $display("FAIL single_addr got %0d accesses first %h exp 1 at 100", a_log.size(), a_log[0]);
    end
    checks++;
    if (arready[0] !== 1'b1) begin
      errors++; $display("FAIL single_arready_after got %b exp 1", arready[0]);
    end
  endtask

  task automatic test_incr;
    logic [7:0] id = 8'($urandom);
    do_ar(0, id, 32'h200, 4'd3, 3'd2, 2'b01);
    collect(0, 4, -1, 0);
    checks++;
    if (a_log.size() != 4) begin
      errors++; $display("FAIL incr_access_count got %0d exp 4", a_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_log[i] !== 32'h200 + 32'(4 * i) || got_data[i] !== mem_rd(32'h200 + 32'(4 * i))
          || got_last[i] !== (i == 3) || got_id[i] !== id) begin
        errors++;
        $display("FAIL incr_beat%0d A %h RDATA %h RLAST %b RID %h exp %h %h %b %h", i, a_log[i],
                 got_data[i], got_last[i], got_id[i], 32'h200 + 32'(4 * i),
                 mem_rd(32'h200 + 32'(4 * i)), i == 3, id);
      end
      if (i > 0) begin
        checks++;
        if (got_first[i] - got_first[i-1] != 3) begin
          errors++; $display("FAIL incr_spacing%0d got %0d exp 3", i, got_first[i] - got_first[i-1]);
        end
      end
    end
  endtask

  task automatic test_fixed;
    do_ar(0, 8'h3C, 32'h300, 4'd2, 3'd2, 2'b00);
    collect(0, 3, -1, 0);
    checks++;
    if (a_log.size() != 3) begin
      errors++; $display("FAIL fixed_access_count got %0d exp 3", a_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_log[i] !== 32'h300 || got_data[i] !== mem_rd(32'h300) || got_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL fixed_beat%0d A %h RDATA %h RLAST %b exp 300 %h %b", i, a_log[i],
                 got_data[i], got_last[i], mem_rd(32'h300), i == 2);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] base = {$urandom, 2'b00};
    do_ar(0, 8'h11, base, 4'd3, 3'd2, 2'b01);
    collect(0, 4, 1, 5);
    checks++;
    if (st_data.size() != 5) begin
      errors++; $display("FAIL bp_stall_len got %0d exp 5", st_data.size());
    end
    for (int k = 0; k < st_data.size(); k++) begin
      checks++;
      if (st_data[k] !== mem_rd(base + 32'd4) || st_last[k] !== 1'b0 || st_alog[k] != 2 || st_ceb[k] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d RDATA %h RLAST %b accesses %0d CEB %b exp %h 0 2 1", k,
                 st_data[k], st_last[k], st_alog[k], st_ceb[k], mem_rd(base + 32'd4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_data[i] !== mem_rd(base + 32'(4 * i)) || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL bp_beat%0d RDATA %h RLAST %b exp %h %b", i, got_data[i], got_last[i],
                 mem_rd(base + 32'(4 * i)), i == 3);
      end
    end
    checks++;
    if (got_first[2] - got_first[1] != 8) begin
      errors++; $display("FAIL bp_spacing got %0d exp 8", got_first[2] - got_first[1]);
    end
  endtask

  task automatic test_interlock;
    @(negedge clk);
    isnot_writing = 1'b0;
    arid = 8'h77; araddr = 32'h440; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid[0] = 1'b1;
    a_log.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (arready[0] !== 1'b0 || isnot_reading[0] !== 1'b1) begin
        errors++;
        $display("FAIL interlock_block%0d ARREADY %b isnot_reading %b exp 0 1", k, arready[0], isnot_reading[0]);
      end
    end
    isnot_writing = 1'b1;
    #1;
    checks++;
    if (arready[0] !== 1'b1) begin
      errors++; $display("FAIL interlock_release ARREADY %b exp 1", arready[0]);
    end
    @(posedge clk);
    #1 arvalid[0] = 1'b0;
    checks++;
    if (isnot_reading[0] !== 1'b0) begin
      errors++; $display("FAIL interlock_handshake isnot_reading %b exp 0", isnot_reading[0]);
    end
    collect(0, 1, -1, 0);
    checks++;
    if (got_data[0] !== mem_rd(32'h440) || got_id[0] !== 8'h77) begin
      errors++; $display("FAIL interlock_beat RDATA %h RID %h exp %h 77", got_data[0], got_id[0], mem_rd(32'h440));
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    logic [31:0] base = {$urandom, 2'b00};
    do_ar(0, 8'h21, base, 4'd3, 3'd2, 2'b01);
    rready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[0] && n < 20);
    checks++;
    if (!rvalid[0]) begin
      errors++; $display("FAIL rstmid_first_beat_timeout waited %0d", n);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (isnot_reading[0] !== 1'b0 || rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_wait isnot_reading %b RVALID %b exp 0 0", isnot_reading[0], rvalid[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid[0], rlast[0], ceb[0], isnot_reading[0], arready[0]} !== 5'b00110) begin
      errors++;
      $display("FAIL rstmid_release got %b exp 00110",
               {rvalid[0], rlast[0], ceb[0], isnot_reading[0], arready[0]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = {$urandom, 2'b00};
    do_ar(0, 8'h42, base, 4'd1, 3'd2, 2'b01);
    collect(0, 2, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_data[i] !== mem_rd(base + 32'(4 * i)) || got_last[i] !== (i == 1) || got_id[i] !== 8'h42) begin
        errors++;
        $display("FAIL rstmid_after_beat%0d RDATA %h RLAST %b RID %h exp %h %b 42", i, got_data[i],
                 got_last[i], got_id[i], mem_rd(base + 32'(4 * i)), i == 1);
      end
    end
  endtask

  task automatic test_mem_lat2;
    do_ar(1, 8'h5A, 32'h100, 4'd0, 3'd2, 2'b01);
    collect(1, 1, -1, 0);
    checks++;
    if (got_first[0] !== 4) begin
      errors++; $display("FAIL lat2_latency got %0d exp 4", got_first[0]);
    end
    checks++;
    if (got_data[0] !== 32'hDEAD_BEEF || got_last[0] !== 1'b1 || got_id[0] !== 8'h5A) begin
      errors++;
      $display("FAIL lat2_beat RDATA %h RLAST %b RID %h exp DEADBEEF 1 5A", got_data[0], got_last[0], got_id[0]);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < 8; t++) begin
        logic [7:0]  id    = 8'($urandom);
        logic [31:0] base  = $urandom;
        logic [3:0]  len   = 4'($urandom_range(0, 15));
        logic [2:0]  size  = 3'($urandom_range(0, 7));
        logic [1:0]  burst = 2'($urandom_range(0, 3));
        int          sb    = $urandom_range(0, 15);
        int          sc    = $urandom_range(0, 3);
        int          lat   = s + 1;
        do_ar(s, id, base, len, size, burst);
        collect(s, int'(len) + 1, sb, sc);
        checks++;
        if (a_log.size() != int'(len) + 1 || got_first[0] != 2 + lat) begin
          errors++;
          $display("FAIL rand_d%0d_t%0d accesses %0d latency %0d exp %0d %0d", s, t,
                   a_log.size(), got_first[0], int'(len) + 1, 2 + lat);
        end
        for (int i = 0; i <= int'(len); i++) begin
          logic [31:0] ea = exp_addr(base, i, size, burst);
          checks++;
          if (a_log[i] !== ea || got_data[i] !== mem_rd(ea) || got_last[i] !== (i == int'(len))
              || got_id[i] !== id || got_resp[i] !== 2'b00) begin
            errors++;
            $display("FAIL rand_d%0d_t%0d_beat%0d A %h RDATA %h RLAST %b RID %h RRESP %b exp %h %h %b %h 00",
                     s, t, i, a_log[i], got_data[i], got_last[i], got_id[i], got_resp[i],
                     ea, mem_rd(ea), i == int'(len), id);
          end
          if (i > 0) begin
            checks++;
            if (got_first[i] - got_first[i-1] != 2 + lat + ((i - 1 == sb) ? sc : 0)) begin
              errors++;
              $display("FAIL rand_d%0d_t%0d_spacing%0d got %0d exp %0d", s, t, i,
                       got_first[i] - got_first[i-1], 2 + lat + ((i - 1 == sb) ? sc : 0));
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_fixed();
    test_backpressure();
    test_interlock();
    test_reset_mid();
    test_mem_lat2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
